// File: rtl/glitc_pkg.sv
// Shared definitions for the GLITC DNA_PORT reader.
// States, register addresses, status bit indices and control bit positions.
package glitc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } dna_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DNA_LO = 2'd1;
    localparam logic [1:0] ADDR_DNA_HI = 2'd2;
    localparam logic [1:0] ADDR_IDENT  = 2'd3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_VALID = 1;
    localparam int STAT_IGN   = 2;

    localparam int CTRL_START = 31;
    localparam int CTRL_CLEAR = 30;

endpackage

// File: rtl/glitc_dna_reader.sv
// DNA_PORT readout sequencer exposed as four 32-bit user-bus registers.
// Optional GLITC_DNA_AUTOSTART_EN: start a readout right after reset.
module glitc_dna_reader
    import glitc_pkg::*;
#(
    parameter int          DNA_BITS  = 57,
    parameter int          SHIFT_DIV = 1,
    parameter logic [31:0] IDENT     = 32'h444E4152
) (
    input  logic        user_clk_i,
    input  logic        user_rst_i,
    input  logic [1:0]  user_addr_i,
    input  logic [31:0] user_dat_i,
    output logic [31:0] user_dat_o,
    input  logic        user_wr_i,
    input  logic        user_rd_i,
    input  logic        user_sel_i,
    output logic        dna_read_o,
    output logic        dna_shift_o,
    input  logic        dna_dout_i
);

    localparam logic [7:0] DIV_LAST = 8'(SHIFT_DIV - 1);
    localparam logic [6:0] BIT_LAST = 7'(DNA_BITS - 1);

    dna_state_t          r_state;
    dna_state_t          w_state_nxt;
    logic [7:0]          r_div;
    logic [6:0]          r_bits;
    logic [DNA_BITS-1:0] r_shreg;
    logic [DNA_BITS-1:0] r_dna;
    logic                r_valid;
    logic                r_ign;

    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_go;
    logic        w_busy;
    logic        w_tick;
    logic [63:0] w_dna64;
    logic        w_unused;

    assign w_wr_ctrl = user_sel_i & user_wr_i
                     & (user_addr_i == ADDR_CTRL);
    assign w_start   = w_wr_ctrl & user_dat_i[CTRL_START];
    assign w_busy    = (r_state != ST_IDLE);
    assign w_tick    = (r_state == ST_SHIFT) && (r_div == DIV_LAST);
    assign w_dna64   = 64'(r_dna);
    assign w_unused  = &{1'b0, user_rd_i, user_dat_i[29:0]};

`ifdef GLITC_DNA_AUTOSTART_EN
    // High only in the first cycle after reset is released.
    logic r_auto;

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_auto <= 1'b1;
        end else begin
            r_auto <= 1'b0;
        end
    end

    assign w_go = w_start | r_auto;
`else
    assign w_go = w_start;
`endif

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dna_read_o  = 1'b0;
        dna_shift_o = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dna_read_o  = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                dna_shift_o = w_tick;
                if (w_tick && (r_bits == BIT_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            r_div   <= '0;
            r_bits  <= '0;
            r_shreg <= '0;
            r_dna   <= '0;
            r_valid <= 1'b0;
            r_ign   <= 1'b0;
        end else begin
            // A start seen while busy outranks a clear in the same write.
            if (w_start && w_busy) begin
                r_ign <= 1'b1;
            end else if (w_wr_ctrl && user_dat_i[CTRL_CLEAR]) begin
                r_ign <= 1'b0;
            end
            unique case (r_state)
                ST_LOAD: begin
                    r_div   <= '0;
                    r_bits  <= '0;
                    r_shreg <= '0;
                    r_valid <= 1'b0;
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_div   <= '0;
                        r_bits  <= r_bits + 7'd1;
                        r_shreg <= {r_shreg[DNA_BITS-2:0], dna_dout_i};
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_dna   <= r_shreg;
                    r_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        user_dat_o = '0;
        unique case (user_addr_i)
            ADDR_CTRL: begin
                user_dat_o[STAT_BUSY]  = w_busy;
                user_dat_o[STAT_VALID] = r_valid;
                user_dat_o[STAT_IGN]   = r_ign;
            end
            ADDR_DNA_LO: user_dat_o = w_dna64[31:0];
            ADDR_DNA_HI: user_dat_o = w_dna64[63:32];
            ADDR_IDENT:  user_dat_o = IDENT;
            default:     user_dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_glitc_dna_reader.sv
// Bench for glitc_dna_reader: default and SHIFT_DIV=4 instances, each
// driven by a behavioural DNA_PORT; results checked through a scoreboard.
module tb_glitc_dna_reader;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [31:0] dat;
    logic        wr;
    logic        rd;
    logic        sel_a;
    logic        sel_b;
    logic [31:0] do_a;
    logic [31:0] do_b;
    logic        rd_a;
    logic        sh_a;
    logic        dout_a;
    logic        rd_b;
    logic        sh_b;
    logic        dout_b;
    logic [56:0] m_a = '0;
    logic [56:0] m_b = '0;
    logic [56:0] val_a = '0;
    logic [56:0] val_b = '0;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0_mon = 0;
    int   div_mon = 1;
    bit   mon_b = 1'b0;
    int   nsh = 0;
    int   nrd = 0;
    int   first_sh = -1;
    int   last_sh = -1;
    int   rd_rel = -1;
    int   bad = 0;
    int   overlap = 0;
    logic [31:0] old_lo = '0;
    logic [31:0] old_hi = '0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    glitc_dna_reader u_dut_a (
        .user_clk_i  (clk),
        .user_rst_i  (rst),
        .user_addr_i (addr),
        .user_dat_i  (dat),
        .user_dat_o  (do_a),
        .user_wr_i   (wr),
        .user_rd_i   (rd),
        .user_sel_i  (sel_a),
        .dna_read_o  (rd_a),
        .dna_shift_o (sh_a),
        .dna_dout_i  (dout_a)
    );

    glitc_dna_reader #(.SHIFT_DIV(4)) u_dut_b (
        .user_clk_i  (clk),
        .user_rst_i  (rst),
        .user_addr_i (addr),
        .user_dat_i  (dat),
        .user_dat_o  (do_b),
        .user_wr_i   (wr),
        .user_rd_i   (rd),
        .user_sel_i  (sel_b),
        .dna_read_o  (rd_b),
        .dna_shift_o (sh_b),
        .dna_dout_i  (dout_b)
    );

    // DNA_PORT model: READ loads the ID, SHIFT moves the next bit to DOUT.
    always @(posedge clk) begin
        if (rd_a) m_a <= val_a;
        else if (sh_a) m_a <= {m_a[55:0], 1'b0};
        if (rd_b) m_b <= val_b;
        else if (sh_b) m_b <= {m_b[55:0], 1'b0};
    end
    assign dout_a = m_a[56];
    assign dout_b = m_b[56];

    always @(negedge clk) begin : mon
        logic r;
        logic s;
        r = mon_b ? rd_b : rd_a;
        s = mon_b ? sh_b : sh_a;
        if ((rd_a && sh_a) || (rd_b && sh_b)) overlap++;
        if (r) begin
            nrd++;
            rd_rel = cyc - t0_mon;
        end
        if (s) begin
            if (nsh == 0) first_sh = cyc - t0_mon;
            nsh++;
            last_sh = cyc - t0_mon;
            if ((cyc - t0_mon - 1) % div_mon != 0) bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sample(input bit b, output logic [31:0] st,
                          output logic [31:0] lo, output logic [31:0] hi);
        addr = 2'd0;
        #1 st = b ? do_b : do_a;
        addr = 2'd1;
        #1 lo = b ? do_b : do_a;
        addr = 2'd2;
        #1 hi = b ? do_b : do_a;
        addr = 2'd0;
    endtask

    // Starts a readout in relative cycle 0 and follows it cycle by cycle.
    task automatic run(input bit b, input int budget, input int div,
                       input int poke, input logic [31:0] pdat,
                       input int rst_at, output int bz0, output int bz1,
                       output int vc, output int hold_bad);
        logic [31:0] st;
        logic [31:0] lo;
        logic [31:0] hi;
        bit done;
        done = 1'b0;
        bz0 = -1;
        bz1 = -1;
        vc = -1;
        hold_bad = 0;
        @(posedge clk);
        #1;
        t0_mon = cyc;
        div_mon = div;
        mon_b = b;
        nsh = 0;
        nrd = 0;
        first_sh = -1;
        last_sh = -1;
        rd_rel = -1;
        bad = 0;
        sel_a = !b;
        sel_b = b;
        for (int i = 0; i < budget && !done; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            rst = (i == rst_at);
            wr = (i == 0) || (i == poke);
            dat = (i == 0) ? 32'h8000_0000 : pdat;
            addr = 2'd0;
            @(negedge clk);
            sample(b, st, lo, hi);
            if (st[0]) begin
                if (bz0 < 0) bz0 = i;
                bz1 = i;
            end
            if (i >= 2 && st[1]) begin
                vc = i;
                done = 1'b1;
            end else if ((rst_at < 0 || i <= rst_at)
                         && (lo !== old_lo || hi !== old_hi)) begin
                hold_bad++;
            end
        end
        wr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic pop_check(input bit b, input string tag);
        logic [31:0] st;
        logic [31:0] lo;
        logic [31:0] hi;
        exp_t e;
        sample(b, st, lo, hi);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb got=empty exp=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        end
    endtask

    task automatic push_exp(input logic [56:0] v);
        exp_t e;
        e.lo = v[31:0];
        e.hi = {7'd0, v[56:32]};
        sb.push_back(e);
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] lo;
        logic [31:0] hi;
        int bz0;
        int bz1;
        int vc;
        int hb;

        // Reset with a start presented at the same time: reset must win.
        rst = 1'b1;
        rd = 1'b0;
        addr = 2'd0;
        dat = 32'h8000_0000;
        wr = 1'b1;
        sel_a = 1'b1;
        sel_b = 1'b1;
        nrd = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wr = 1'b0;
        sel_a = 1'b0;
        sel_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(1'b0, st, lo, hi);
            check("rst_status_a", 64'(st), 64'd0);
        end
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_no_read", 64'(nrd), 64'd0);
        addr = 2'd3;
        #1 check("ident", 64'(do_a), 64'h444E4152);
        addr = 2'd0;

        // Default readout with a second start at cycle 20.
        val_a = 57'h1_2345_6789_ABCD_EF;
        old_lo = '0;
        old_hi = '0;
        push_exp(val_a);
        run(1'b0, 80, 1, 20, 32'h8000_0000, -1, bz0, bz1, vc, hb);
        check("a1_busy_first", 64'(bz0), 64'd1);
        check("a1_busy_last", 64'(bz1), 64'd59);
        check("a1_valid_cyc", 64'(vc), 64'd60);
        check("a1_nshift", 64'(nsh), 64'd57);
        check("a1_first_sh", 64'(first_sh), 64'd2);
        check("a1_last_sh", 64'(last_sh), 64'd58);
        check("a1_align", 64'(bad), 64'd0);
        check("a1_read_cyc", 64'(rd_rel), 64'd1);
        check("a1_nread", 64'(nrd), 64'd1);
        check("a1_hold", 64'(hb), 64'd0);
        sample(1'b0, st, lo, hi);
        check("a1_status_ign", 64'(st), 64'h6);
        pop_check(1'b0, "a1");

        // Clear the sticky start_ignored flag.
        @(posedge clk);
        #1;
        sel_a = 1'b1;
        wr = 1'b1;
        dat = 32'h4000_0000;
        @(posedge clk);
        #1;
        wr = 1'b0;
        @(negedge clk);
        sample(1'b0, st, lo, hi);
        check("clear_status", 64'(st), 64'h2);

        // Second readout of an all-zero ID: old value held until valid.
        val_a = '0;
        old_lo = 32'h89AB_CDEF;
        old_hi = 32'h0123_4567;
        push_exp(val_a);
        run(1'b0, 80, 1, -1, 32'h0, -1, bz0, bz1, vc, hb);
        check("a2_valid_cyc", 64'(vc), 64'd60);
        check("a2_hold", 64'(hb), 64'd0);
        check("a2_nshift", 64'(nsh), 64'd57);
        pop_check(1'b0, "a2");

        // SHIFT_DIV=4 instance.
        val_b = 57'h1_2345_6789_ABCD_EF;
        old_lo = '0;
        old_hi = '0;
        push_exp(val_b);
        run(1'b1, 300, 4, -1, 32'h0, -1, bz0, bz1, vc, hb);
        check("b_busy_first", 64'(bz0), 64'd1);
        check("b_busy_last", 64'(bz1), 64'd230);
        check("b_valid_cyc", 64'(vc), 64'd231);
        check("b_nshift", 64'(nsh), 64'd57);
        check("b_first_sh", 64'(first_sh), 64'd5);
        check("b_last_sh", 64'(last_sh), 64'd229);
        check("b_align", 64'(bad), 64'd0);
        check("b_hold", 64'(hb), 64'd0);
        pop_check(1'b1, "b");

        // Reset pulse in cycle 30 of a readout.
        val_a = 57'h0AA_5555_AAAA_5555;
        old_lo = '0;
        old_hi = '0;
        run(1'b0, 45, 1, -1, 32'h0, 30, bz0, bz1, vc, hb);
        check("r_busy_last", 64'(bz1), 64'd30);
        check("r_valid", 64'(vc), -64'sd1);
        check("r_nshift", 64'(nsh), 64'd29);
        check("r_last_sh", 64'(last_sh), 64'd30);
        check("r_hold", 64'(hb), 64'd0);
        sample(1'b0, st, lo, hi);
        check("r_status_a", 64'(st), 64'd0);
        check("r_lo", 64'(lo), 64'd0);
        sample(1'b1, st, lo, hi);
        check("r_status_b", 64'(st), 64'd0);
        check("r_lo_b", 64'(lo), 64'd0);

        check("read_shift_overlap", 64'(overlap), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
